// File: rtl/frame_replay_ctrl.sv
// ARQ frame-store controller: passes mapper frames to the transmit FIFO, captures them to RAM,
// and replays the stored frame on a bad ACK. Define FRAME_REPLAY_STATS_EN for the replay counter.
module frame_replay_ctrl #(
  parameter int FRAME_BYTES = 4164,
  parameter int ADDR_W      = 13,
  parameter int MAX_RETX    = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_frame_data,
  input  logic              i_frame_data_valid,
  input  logic              i_frame_data_fas,
  output logic              o_mapper_ready,
  output logic [7:0]        o_frame_data,
  output logic              o_frame_data_valid,
  output logic              o_frame_data_fas,
  input  logic              i_fifo_ready,
  input  logic              i_arq_en,
  input  logic              i_ack_good,
  input  logic              i_ack_bad,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wr_en,
  output logic [7:0]        o_mem_wr_data,
  output logic              o_mem_rd_en,
  input  logic [7:0]        i_mem_rd_data,
  output logic              o_busy,
  output logic              o_frame_drop,
  output logic [15:0]       o_retx_total
);

  localparam logic [ADDR_W:0] FRAME_LEN = (ADDR_W+1)'(FRAME_BYTES);
  localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(FRAME_BYTES - 1);
  localparam logic [7:0]      MAX_R     = 8'(MAX_RETX);

  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD, REPLAY} state_t;

  state_t            state;
  logic [ADDR_W:0]   byte_cnt;
  logic [ADDR_W:0]   rd_addr;
  logic              arq_r;
  logic [7:0]        retx_r;
  logic              busy_r;
  logic              drop_r;
  logic              rd_pend_p0;
  logic              rd_fas_p0;
  logic              rd_last_p0;
  logic              vld_p1;
  logic              fas_p1;
  logic              last_p1;
  logic [7:0]        data_p1;

  logic pass_mode;
  logic accept;
  logic idle_fas;
  logic consume;
  logic issue;
  logic hold_bad;

  // Reset gates the ready so every output is quiet while i_rst_n is low.
  assign pass_mode      = (state == IDLE) || (state == CAPTURE);
  assign o_mapper_ready = i_rst_n & pass_mode & i_fifo_ready;
  assign accept         = i_frame_data_valid & o_mapper_ready;
  assign idle_fas       = (state == IDLE) & accept & i_frame_data_fas;
  assign consume        = (state == REPLAY) & vld_p1 & i_fifo_ready;
  assign issue          = (state == REPLAY) & ~rd_pend_p0 & (~vld_p1 | consume) & (rd_addr < FRAME_LEN);
  assign hold_bad       = (state == HOLD) & i_ack_bad & ~i_ack_good;
  assign o_busy         = busy_r;
  assign o_frame_drop   = drop_r;

  always_comb begin
    o_frame_data_valid = 1'b0;
    o_frame_data       = '0;
    o_frame_data_fas   = 1'b0;
    o_mem_addr         = '0;
    o_mem_wr_en        = 1'b0;
    o_mem_wr_data      = '0;
    o_mem_rd_en        = 1'b0;
    case (state)
      IDLE: begin
        if (idle_fas) begin
          o_frame_data_valid = 1'b1;
          o_frame_data       = i_frame_data;
          o_frame_data_fas   = 1'b1;
          o_mem_wr_en        = i_arq_en;
          o_mem_wr_data      = i_frame_data;
        end
      end
      CAPTURE: begin
        if (accept) begin
          o_frame_data_valid = 1'b1;
          o_frame_data       = i_frame_data;
          o_mem_wr_en        = arq_r;
          o_mem_wr_data      = i_frame_data;
          o_mem_addr         = byte_cnt[ADDR_W-1:0];
        end
      end
      REPLAY: begin
        o_frame_data_valid = vld_p1;
        o_frame_data       = vld_p1 ? data_p1 : '0;
        o_frame_data_fas   = vld_p1 & fas_p1;
        o_mem_rd_en        = issue;
        o_mem_addr         = rd_addr[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      rd_addr    <= '0;
      arq_r      <= 1'b0;
      retx_r     <= '0;
      busy_r     <= 1'b0;
      drop_r     <= 1'b0;
      rd_pend_p0 <= 1'b0;
      rd_fas_p0  <= 1'b0;
      rd_last_p0 <= 1'b0;
      vld_p1     <= 1'b0;
      fas_p1     <= 1'b0;
      last_p1    <= 1'b0;
    end else begin
      drop_r <= 1'b0;
      case (state)
        IDLE: begin
          if (idle_fas) begin
            byte_cnt <= {{ADDR_W{1'b0}}, 1'b1};
            arq_r    <= i_arq_en;
            state    <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (accept) begin
            if (byte_cnt == LAST_IDX) begin
              byte_cnt <= '0;
              retx_r   <= '0;
              busy_r   <= arq_r;
              state    <= arq_r ? HOLD : IDLE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (i_ack_good) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else if (i_ack_bad) begin
            if (retx_r < MAX_R) begin
              retx_r  <= retx_r + 1'b1;
              rd_addr <= '0;
              state   <= REPLAY;
            end else begin
              drop_r <= 1'b1;
              busy_r <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        REPLAY: begin
          // stage p0: one RAM read in flight, tagged with its frame position
          rd_pend_p0 <= issue;
          if (issue) begin
            rd_addr    <= rd_addr + 1'b1;
            rd_fas_p0  <= (rd_addr == '0);
            rd_last_p0 <= (rd_addr == LAST_IDX);
          end
          // stage p1: one-byte output register toward the transmit FIFO
          if (rd_pend_p0) begin
            vld_p1  <= 1'b1;
            fas_p1  <= rd_fas_p0;
            last_p1 <= rd_last_p0;
          end else if (consume) begin
            vld_p1 <= 1'b0;
          end
          if (consume && last_p1) state <= HOLD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (rd_pend_p0) data_p1 <= i_mem_rd_data;
  end

`ifdef FRAME_REPLAY_STATS_EN
  logic [15:0] retx_total;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      retx_total <= '0;
    end else if (hold_bad && (retx_r < MAX_R) && (retx_total != 16'hFFFF)) begin
      retx_total <= retx_total + 1'b1;
    end
  end

  assign o_retx_total = retx_total;
`else
  logic unused_stats;
  assign unused_stats = hold_bad;
  assign o_retx_total = '0;
`endif

endmodule

// File: tb/tb_frame_replay_ctrl.sv
// Self-checking bench for frame_replay_ctrl: random frames, a RAM model and an expected-output queue.
module tb_frame_replay_ctrl;

  localparam int FB   = 64;
  localparam int AW   = 6;
  localparam int MAXR = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    frame_data = '0;
  logic          frame_data_valid = 1'b0;
  logic          frame_data_fas = 1'b0;
  logic          mapper_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_fas;
  logic          fifo_ready = 1'b1;
  logic          arq_en = 1'b0;
  logic          ack_good = 1'b0;
  logic          ack_bad = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;
  logic          mem_rd_en;
  logic [7:0]    mem_rd_data = '0;
  logic          busy;
  logic          frame_drop;
  logic [15:0]   retx_total;

  frame_replay_ctrl #(.FRAME_BYTES(FB), .ADDR_W(AW), .MAX_RETX(MAXR)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_frame_data(frame_data), .i_frame_data_valid(frame_data_valid), .i_frame_data_fas(frame_data_fas),
    .o_mapper_ready(mapper_ready),
    .o_frame_data(out_data), .o_frame_data_valid(out_valid), .o_frame_data_fas(out_fas),
    .i_fifo_ready(fifo_ready), .i_arq_en(arq_en), .i_ack_good(ack_good), .i_ack_bad(ack_bad),
    .o_mem_addr(mem_addr), .o_mem_wr_en(mem_wr_en), .o_mem_wr_data(mem_wr_data),
    .o_mem_rd_en(mem_rd_en), .i_mem_rd_data(mem_rd_data),
    .o_busy(busy), .o_frame_drop(frame_drop), .o_retx_total(retx_total)
  );

  always #5 clk = ~clk;

  // external single-port frame RAM, one-cycle read latency
  logic [7:0] ram [0:FB-1];
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= ram[mem_addr];
  end

  int n_chk = 0;
  int n_bad = 0;
  int fifo_mode = 0;
  int n_out = 0;
  int wr_cnt = 0;
  int drop_cnt = 0;
  int replays = 0;
  logic [8:0] exp_q[$];
  int rd_q[$];
  logic [7:0] frame [0:FB-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (fifo_mode)
      0:       fifo_ready = 1'b1;
      1:       fifo_ready = ($urandom_range(0, 7) == 0);
      default: fifo_ready = $urandom_range(0, 1) == 1;
    endcase
  end

  // output monitor: every transfer to the FIFO must match the next expected byte
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && fifo_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_byte", 32'd1, 32'd0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("byte", {24'd0, out_data}, {24'd0, e[7:0]});
          chk("fas", {31'd0, out_fas}, {31'd0, e[8]});
          n_out++;
        end
      end
      if (mem_wr_en) wr_cnt++;
      if (mem_rd_en) rd_q.push_back(int'(mem_addr));
      if (frame_drop) drop_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [7:0] d, input logic f);
    int g;
    logic acc;
    g = 0;
    acc = 1'b0;
    frame_data = d;
    frame_data_fas = f;
    frame_data_valid = 1'b1;
    while (!acc && g < 400) begin
      @(negedge clk);
      acc = mapper_ready;
      g++;
    end
    tick();
    frame_data_valid = 1'b0;
    frame_data_fas = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // Sends FAS + FB-1 random bytes; all are expected on the output. stray_at pulses a bad ACK mid-frame.
  task automatic send_frame(input logic arq, input int stray_at);
    arq_en = arq;
    for (int i = 0; i < FB; i++) begin
      frame[i] = 8'($urandom);
      exp_q.push_back({(i == 0), frame[i]});
      if (i == stray_at) ack_bad = 1'b1;
      push_beat(frame[i], i == 0);
      ack_bad = 1'b0;
    end
    arq_en = 1'b0;
  endtask

  task automatic pulse_ack(input logic g, input logic b);
    ack_good = g;
    ack_bad = b;
    tick();
    ack_good = 1'b0;
    ack_bad = 1'b0;
  endtask

  task automatic expect_replay();
    for (int i = 0; i < FB; i++) exp_q.push_back({(i == 0), frame[i]});
    replays++;
  endtask

  task automatic wait_drain(input string tag);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk(tag, exp_q.size(), 32'd0);
    exp_q.delete();
    tick();
    tick();
  endtask

  task automatic chk_sweep(input string tag);
    int errs;
    errs = 0;
    for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] != i) errs++;
    chk({tag, "_cnt"}, rd_q.size(), FB);
    chk({tag, "_addr"}, errs, 0);
    rd_q.delete();
  endtask

  task automatic chk_ram(input string tag);
    int errs;
    errs = 0;
    for (int i = 0; i < FB; i++) if (ram[i] !== frame[i]) errs++;
    chk(tag, errs, 0);
  endtask

  function automatic logic [15:0] exp_total();
`ifdef FRAME_REPLAY_STATS_EN
    return 16'(replays);
`else
    return 16'd0;
`endif
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {25'd0, mapper_ready, out_valid, out_fas, mem_wr_en, mem_rd_en, busy, frame_drop}, 32'd0);
    chk({tag, "_data"}, {8'd0, out_data, mem_wr_data, 2'd0, mem_addr}, 32'd0);
    chk({tag, "_total"}, {16'd0, retx_total}, 32'd0);
  endtask

  initial begin
    int base, w0, lat;
    // reset state with busy-looking inputs
    fifo_ready = 1'b1;
    frame_data_valid = 1'b1;
    frame_data_fas = 1'b1;
    frame_data = 8'hA5;
    arq_en = 1'b1;
    #23;
    chk_quiet("reset");
    frame_data_valid = 1'b0;
    frame_data_fas = 1'b0;
    arq_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // non-FAS beats in IDLE are discarded
    w0 = wr_cnt;
    for (int i = 0; i < 5; i++) push_beat(8'($urandom), 1'b0);
    tick();
    chk("idle_discard_out", n_out, 0);
    chk("idle_discard_wr", wr_cnt - w0, 0);

    // pass-through with ARQ off under random FIFO backpressure
    fifo_mode = 2;
    w0 = wr_cnt;
    send_frame(1'b0, -1);
    wait_drain("pass_drain");
    fifo_mode = 0;
    tick();
    chk("pass_cnt", n_out, FB);
    chk("pass_no_wr", wr_cnt - w0, 0);
    @(negedge clk);
    chk("pass_busy", busy, 1'b0);
    chk("pass_ready", mapper_ready, 1'b1);
    tick();

    // capture with a stray bad ACK mid-frame, then good+bad together in HOLD
    w0 = wr_cnt;
    send_frame(1'b1, 20);
    wait_drain("cap_drain");
    chk("cap_wr_cnt", wr_cnt - w0, FB);
    chk_ram("cap_ram");
    @(negedge clk);
    chk("cap_busy", busy, 1'b1);
    chk("cap_ready", mapper_ready, 1'b0);
    chk("cap_no_replay", rd_q.size(), 0);
    tick();
    pulse_ack(1'b1, 1'b1);
    tick();
    tick();
    @(negedge clk);
    chk("both_busy", busy, 1'b0);
    chk("both_ready", mapper_ready, 1'b1);
    chk("both_no_rd", rd_q.size(), 0);
    chk("both_no_drop", drop_cnt, 0);
    tick();

    // single bad ACK, sparse FIFO ready, then good ACK
    send_frame(1'b1, -1);
    wait_drain("f2_drain");
    fifo_mode = 1;
    expect_replay();
    pulse_ack(1'b0, 1'b1);
    wait_drain("rep1_drain");
    fifo_mode = 0;
    tick();
    chk_sweep("rep1_sweep");
    @(negedge clk);
    chk("rep1_hold_busy", busy, 1'b1);
    chk("rep1_hold_ready", mapper_ready, 1'b0);
    chk("rep1_total", {16'd0, retx_total}, {16'd0, exp_total()});
    tick();
    pulse_ack(1'b1, 1'b0);
    @(negedge clk);
    chk("rep1_idle_busy", busy, 1'b0);
    chk("rep1_idle_ready", mapper_ready, 1'b1);
    tick();

    // retry exhaustion: MAXR replays, the next bad ACK drops the frame
    send_frame(1'b1, -1);
    wait_drain("f3_drain");
    for (int r = 0; r < MAXR; r++) begin
      expect_replay();
      pulse_ack(1'b0, 1'b1);
      if (r == 0) begin
        lat = 0;
        do begin
          @(negedge clk);
          lat++;
        end while (!out_valid && lat < 10);
        chk("rep_latency", lat, 3);
      end
      wait_drain("retry_drain");
      chk_sweep("retry_sweep");
    end
    chk("retry_total", {16'd0, retx_total}, {16'd0, exp_total()});
    chk("retry_no_drop_yet", drop_cnt, 0);
    pulse_ack(1'b0, 1'b1);
    @(negedge clk);
    chk("drop_pulse", frame_drop, 1'b1);
    chk("drop_busy", busy, 1'b0);
    chk("drop_no_rd", rd_q.size(), 0);
    tick();
    @(negedge clk);
    chk("drop_once", drop_cnt, 1);
    chk("drop_low", frame_drop, 1'b0);
    chk("drop_ready", mapper_ready, 1'b1);
    tick();

    // reset in the middle of a replay
    send_frame(1'b1, -1);
    wait_drain("f4_drain");
    base = n_out;
    expect_replay();
    pulse_ack(1'b0, 1'b1);
    lat = 0;
    while (n_out < base + 20 && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    chk("mid_reached", n_out - base, 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("midrst");
    exp_q.delete();
    rd_q.delete();
    replays = 0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    w0 = wr_cnt;
    base = n_out;
    arq_en = 1'b1;
    for (int i = 0; i < 6; i++) push_beat(8'($urandom), 1'b0);
    arq_en = 1'b0;
    tick();
    chk("post_rst_discard", n_out - base, 0);
    chk("post_rst_no_wr", wr_cnt - w0, 0);
    chk("post_rst_busy", busy, 1'b0);
    send_frame(1'b0, -1);
    wait_drain("post_rst_drain");
    chk("post_rst_pass", n_out - base, FB);
    chk("post_rst_total", {16'd0, retx_total}, {16'd0, exp_total()});

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
